// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the bit-period helper
// that the transmitter also uses.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Byte-side port bundle of the UART receiver: valid/ready byte handshake plus
// the single-cycle framing and overrun status pulses.
interface uart_receiver_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  frame_error;
  logic                  overrun;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_error,
    output overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_error,
    input  overrun,
    output rx_ready
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx pin plus a previous-value
// register for falling-edge (start bit) detection.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx_signal,
  output logic line_sync,
  output logic start_edge
);

  logic sync_meta;
  logic sync_line;
  logic sync_prev;

  // Idle line is high, so every stage comes out of reset at 1 to avoid a
  // false start edge on release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b1;
      sync_line <= 1'b1;
      sync_prev <= 1'b1;
    end else begin
      sync_meta <= rx_signal;
      sync_line <= sync_meta;
      sync_prev <= sync_line;
    end
  end

  assign line_sync  = sync_line;
  assign start_edge = sync_prev & ~sync_line;

endmodule

// File: rtl/uart_receiver.sv
// UART receive path (start, DATA_WIDTH bits LSB first, stop) with a single
// holding register on a valid/ready handshake. Build option: UART_RX_MAJORITY_EN.
//
// state | meaning
// IDLE  | waiting for a start edge
// START | counting to mid start bit, then confirming it is still low
// DATA  | sampling data bits once per bit period
// STOP  | sampling the stop bit; deliver or flag a framing error
// BREAK | line held low after a framing error; wait for it to go high
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115_200,
  parameter int CLK_FREQ   = 50_000_000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ena,
  input  logic            rx_signal,
  uart_receiver_if.master rx_bus
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int IDX_W        = $clog2(DATA_WIDTH + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  logic line_sync;
  logic start_edge;
  logic bit_sample;

  rx_state_t             state, state_next;
  logic [CNT_W-1:0]      cnt, cnt_next;
  logic [IDX_W-1:0]      bit_idx, idx_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic                  deliver;
  logic                  ferr_set;

  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  ferr_q;
  logic                  ovr_q;

  uart_rx_sync u_sync (
    .clk        (clk),
    .reset      (reset),
    .rx_signal  (rx_signal),
    .line_sync  (line_sync),
    .start_edge (start_edge)
  );

`ifdef UART_RX_MAJORITY_EN
  // hist_1/hist_2 hold the line at counter values 1 and 2 when the counter
  // reaches 0, so the vote spans the three cycles ending at the sample point.
  logic hist_1;
  logic hist_2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_1 <= 1'b1;
      hist_2 <= 1'b1;
    end else begin
      hist_1 <= line_sync;
      hist_2 <= hist_1;
    end
  end

  assign bit_sample = (hist_2 & hist_1) | (hist_2 & line_sync) | (hist_1 & line_sync);
`else
  assign bit_sample = line_sync;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      bit_idx   <= idx_next;
      shift_reg <= shift_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = bit_idx;
    shift_next = shift_reg;
    deliver    = 1'b0;
    ferr_set   = 1'b0;

    unique case (state)
      IDLE: begin
        if (start_edge) begin
          state_next = START;
          cnt_next   = CNT_HALF;
        end
      end

      START: begin
        if (cnt == '0) begin
          if (!bit_sample) begin
            state_next = DATA;
            cnt_next   = CNT_FULL;
            idx_next   = '0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt == '0) begin
          shift_next = {bit_sample, shift_reg[DATA_WIDTH-1:1]};
          cnt_next   = CNT_FULL;
          if (bit_idx == IDX_LAST) begin
            state_next = STOP;
          end else begin
            idx_next = bit_idx + IDX_W'(1);
          end
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end

      // Leaving at mid stop bit leaves half a bit of slack for the next start.
      STOP: begin
        if (cnt == '0) begin
          if (bit_sample) begin
            deliver    = 1'b1;
            state_next = IDLE;
          end else begin
            ferr_set   = 1'b1;
            state_next = BREAK;
          end
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end

      BREAK: begin
        if (line_sync) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (!ena) begin
      state_next = IDLE;
      cnt_next   = '0;
      idx_next   = '0;
      deliver    = 1'b0;
      ferr_set   = 1'b0;
    end
  end

  // A delivery may land in the same cycle the consumer takes the old byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ferr_q <= ferr_set;
      ovr_q  <= deliver & valid_q & ~rx_bus.rx_ready;
      if (deliver && (!valid_q || rx_bus.rx_ready)) begin
        data_q  <= shift_reg;
        valid_q <= 1'b1;
      end else if (valid_q && rx_bus.rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_bus.rx_data     = data_q;
  assign rx_bus.rx_valid    = valid_q;
  assign rx_bus.frame_error = ferr_q;
  assign rx_bus.overrun     = ovr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at default 50 MHz / 115200 baud: frame
// timing, glitch rejection, framing error with break, overrun, abort cases.
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int CPB = 434;

`ifdef UART_RX_MAJORITY_EN
  localparam bit GLITCH = 1'b1;
`else
  localparam bit GLITCH = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic ena;
  logic rx_signal;

  int checks = 0;
  int errors = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;

  logic       valid_before;
  logic       valid_after;
  logic [7:0] data_after;

  uart_receiver_if #(.DATA_WIDTH(8)) rx_bus ();

  uart_receiver #(
    .DATA_WIDTH (8),
    .BAUD_RATE  (115_200),
    .CLK_FREQ   (50_000_000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ena       (ena),
    .rx_signal (rx_signal),
    .rx_bus    (rx_bus.master)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (rx_bus.frame_error === 1'b1) ferr_cnt++;
    if (rx_bus.overrun === 1'b1) ovr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic consume();
    @(negedge clk);
    rx_bus.rx_ready = 1'b1;
    @(negedge clk);
    rx_bus.rx_ready = 1'b0;
  endtask

  // Negedge n of the frame (n = CPB*bit + offset) drives the pin; the stop
  // sample falls between negedges 4124 and 4125, so valid is captured on both
  // sides of the delivery edge. abort: 1 = reset, 2 = ena low, mid data bit 4.
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit ready_at_del,
                            input int abort, input bit glitch);
    logic [9:0] bits;
    int n;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < CPB; j++) begin
        @(negedge clk);
        n = CPB * i + j;
        if (n == 4125) begin
          valid_before = rx_bus.rx_valid;
          if (ready_at_del) rx_bus.rx_ready = 1'b1;
        end
        if (n == 4126) begin
          valid_after = rx_bus.rx_valid;
          data_after  = rx_bus.rx_data;
          if (ready_at_del) rx_bus.rx_ready = 1'b0;
        end
        if (i == 5 && j == 200) begin
          if (abort == 1) reset = 1'b1;
          if (abort == 2) ena = 1'b0;
        end
        if (i == 5 && j == 202) begin
          reset = 1'b0;
          ena   = 1'b1;
        end
        rx_signal = (glitch && j == 217) ? ~bits[i] : bits[i];
      end
    end
  endtask

  initial begin
    int f0;
    int o0;
    reset = 1'b1;
    ena = 1'b1;
    rx_signal = 1'b1;
    rx_bus.rx_ready = 1'b0;
    idle_cycles(3);
    chk("reset_data", 32'(rx_bus.rx_data), 32'h00);
    chk("reset_valid", 32'(rx_bus.rx_valid), 32'h0);
    chk("reset_ferr", 32'(rx_bus.frame_error), 32'h0);
    chk("reset_ovr", 32'(rx_bus.overrun), 32'h0);
    chk("reset_state", 32'(dut.state), 32'(IDLE));
    reset = 1'b0;
    idle_cycles(5);

    // 0xA5: valid rises exactly one cycle after the stop sample
    send_frame(8'hA5, 1'b1, 1'b0, 0, 1'b0);
    chk("a5_valid_before", 32'(valid_before), 32'h0);
    chk("a5_valid_after", 32'(valid_after), 32'h1);
    chk("a5_data", 32'(data_after), 32'hA5);
    consume();
    @(negedge clk);
    chk("a5_consumed", 32'(rx_bus.rx_valid), 32'h0);
    idle_cycles(20);

    // 100-cycle low glitch on idle line
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    rx_signal = 1'b0;
    idle_cycles(100);
    rx_signal = 1'b1;
    idle_cycles(400);
    chk("glitch_valid", 32'(rx_bus.rx_valid), 32'h0);
    chk("glitch_state", 32'(dut.state), 32'(IDLE));
    chk("glitch_pulses", 32'(ferr_cnt - f0 + ovr_cnt - o0), 32'h0);

    // 0x3C with low stop bit, line held low for two frames
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 0, 1'b0);
    chk("ferr_pulse", 32'(ferr_cnt - f0), 32'h1);
    chk("ferr_valid", 32'(valid_after), 32'h0);
    idle_cycles(2 * 10 * CPB);
    chk("break_state", 32'(dut.state), 32'(BREAK));
    rx_signal = 1'b1;
    idle_cycles(10);
    chk("break_exit", 32'(dut.state), 32'(IDLE));
    chk("ferr_once", 32'(ferr_cnt - f0), 32'h1);
    send_frame(8'h55, 1'b1, 1'b0, 0, 1'b0);
    chk("post_break_data", 32'(data_after), 32'h55);
    chk("post_break_valid", 32'(valid_after), 32'h1);
    consume();
    idle_cycles(20);

    // Overrun: 0x11 then 0x22 back-to-back, never consumed
    o0 = ovr_cnt;
    send_frame(8'h11, 1'b1, 1'b0, 0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 0, 1'b0);
    idle_cycles(5);
    chk("ovr_pulse", 32'(ovr_cnt - o0), 32'h1);
    chk("ovr_data_kept", 32'(rx_bus.rx_data), 32'h11);
    chk("ovr_valid_kept", 32'(rx_bus.rx_valid), 32'h1);
    consume();
    idle_cycles(20);

    // Same, but 0x11 consumed on the delivery cycle of 0x22
    o0 = ovr_cnt;
    send_frame(8'h11, 1'b1, 1'b0, 0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b1, 0, 1'b0);
    idle_cycles(5);
    chk("no_ovr_pulse", 32'(ovr_cnt - o0), 32'h0);
    chk("no_ovr_data", 32'(rx_bus.rx_data), 32'h22);
    chk("no_ovr_valid", 32'(rx_bus.rx_valid), 32'h1);
    consume();
    idle_cycles(20);

    // Reset during data bit 4
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    send_frame(8'hF3, 1'b1, 1'b0, 1, 1'b0);
    idle_cycles(5);
    chk("rst_abort_valid", 32'(rx_bus.rx_valid), 32'h0);
    chk("rst_abort_data", 32'(rx_bus.rx_data), 32'h00);
    chk("rst_abort_pulses", 32'(ferr_cnt - f0 + ovr_cnt - o0), 32'h0);
    send_frame(8'h81, 1'b1, 1'b0, 0, 1'b0);
    chk("rst_next_data", 32'(data_after), 32'h81);
    chk("rst_next_valid", 32'(valid_after), 32'h1);
    idle_cycles(20);

    // ena low during data bit 4, with 0x81 still held unconsumed
    send_frame(8'hF3, 1'b1, 1'b0, 2, 1'b0);
    idle_cycles(5);
    chk("ena_abort_data", 32'(rx_bus.rx_data), 32'h81);
    chk("ena_abort_valid", 32'(rx_bus.rx_valid), 32'h1);
    chk("ena_abort_pulses", 32'(ferr_cnt - f0 + ovr_cnt - o0), 32'h0);
    consume();
    @(negedge clk);
    chk("ena_consumed", 32'(rx_bus.rx_valid), 32'h0);
    send_frame(8'h81, 1'b1, 1'b0, 0, 1'b0);
    chk("ena_next_data", 32'(data_after), 32'h81);
    chk("ena_next_valid", 32'(valid_after), 32'h1);
    consume();
    idle_cycles(20);

    // 0x96, with a one-cycle inverted glitch at every sample point when voting
    f0 = ferr_cnt;
    send_frame(8'h96, 1'b1, 1'b0, 0, GLITCH);
    chk("vote_data", 32'(data_after), 32'h96);
    chk("vote_valid", 32'(valid_after), 32'h1);
    chk("vote_no_ferr", 32'(ferr_cnt - f0), 32'h0);
    idle_cycles(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receive path for the Basys3 link; converts the asynchronous `rx_signal` pin into bytes presented on a valid/ready handshake. The frame format is 8N1 by default: one start bit, DATA_WIDTH data bits LSB first, and one stop bit. It is the counterpart of the link transmitter and sits between the `uio_in[1]` pad and the command/loopback logic inside the `uart` wrapper. Framing and overrun faults are reported as single-cycle status pulses.

## Interface
- DATA_WIDTH, 8: data bits per frame.
- BAUD_RATE, 115_200: line rate in bit/s.
- CLK_FREQ, 50_000_000: `clk` frequency in Hz.
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- ena  in  1  block enable; low forces IDLE.
- rx_signal  in  1  serial line, idle high; asynchronous to `clk`.
- rx_data  out  DATA_WIDTH  received byte (holding register).
- rx_valid  out  1  `rx_data` holds an unconsumed byte.
- rx_ready  in  1  consumer accepts `rx_data` when high together with `rx_valid`.
- frame_error  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: a byte completed while the holding register was full; the new byte is dropped.

## Operation
- CLKS_PER_BIT = CLK_FREQ / BAUD_RATE, integer division (434 at defaults). HALF_BIT = CLKS_PER_BIT / 2 (217).
- `rx_signal` passes through a 2-FF synchronizer; the synchronizer resets to 1.
- Edge detect: a start is seen when the synchronized line is 0 and its previous value was 1.
- FSM states are IDLE, START, DATA, STOP, BREAK.
  - IDLE -> START on a start edge; the bit counter is loaded with HALF_BIT-1.
  - START: when the counter reaches 0, the line is sampled at mid-bit. Low -> DATA, counter = CLKS_PER_BIT-1, bit index = 0. High -> IDLE (glitch rejected, no status pulse).
  - DATA: each counter expiry shifts the sample into the MSB of the shift register (LSB-first reception) and reloads the counter. After DATA_WIDTH samples -> STOP.
  - STOP: on counter expiry, sample the line. If 1 -> deliver the byte and go to IDLE. If 0 -> pulse `frame_error`, discard the byte, go to BREAK.
  - BREAK: wait until the synchronized line is 1, then go to IDLE.
- Delivery:
  - If `rx_valid`=0, or `rx_ready`=1 in the same cycle, load `rx_data` and set `rx_valid`.
  - Otherwise pulse `overrun`; the old byte and `rx_valid` are kept.
- Handshake:
  - `rx_valid` clears on the cycle after `rx_valid && rx_ready` unless a new delivery occurs in that same cycle.
  - `rx_data` is stable while `rx_valid` is high.
- `ena` low forces the FSM to IDLE and aborts any frame in progress without a status pulse. The holding register and `rx_valid` are retained, and the handshake still works.
- Reset values: `rx_data`=0, `rx_valid`=0, `frame_error`=0, `overrun`=0, FSM=IDLE, counters=0. Reset mid-frame aborts the frame silently.

## Timing
- Edge detection occurs 2–3 `clk` cycles after the pin falls (synchronizer delay).
- Counting from the edge-detect cycle:
  - start sample at +HALF_BIT;
  - data bit k sampled at +HALF_BIT + (k+1)·CLKS_PER_BIT;
  - stop sample at +HALF_BIT + (DATA_WIDTH+1)·CLKS_PER_BIT.
- `rx_valid`, `frame_error` and `overrun` assert in the cycle after the stop sample.
- Returning to IDLE at mid-stop-bit allows back-to-back frames with up to half a bit of clock mismatch.
- Throughput is one byte per frame time; no internal queue beyond the single holding register.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - every bit sample is the 2-of-3 majority of the synchronized line at counter values 2, 1 and 0, i.e. the three cycles ending at the sample point;
  - the start check uses the same vote.
- Undefined: a single sample at counter 0.
- Sample timing and handshake are identical in both builds.

## Structure
- `uart_pkg` holds:
  - the `rx_state_t` enum (IDLE, START, DATA, STOP, BREAK);
  - a `clks_per_bit(CLK_FREQ, BAUD_RATE)` function, shared with the transmitter.
- One sub-module, `uart_rx_sync`: the 2-FF synchronizer plus previous-value register, producing `line_sync` and `start_edge`.
- Counter width is `$clog2(CLKS_PER_BIT)`; bit-index width is `$clog2(DATA_WIDTH+1)`.

## Test plan
- Frame 0xA5 at 115200 baud, with `rx_ready` low -> `rx_data`=0xA5 and `rx_valid`=1 exactly one cycle after the stop sample. Raise `rx_ready` for one cycle -> `rx_valid`=0 on the next cycle.
- A 100-cycle low glitch on the idle line -> no `rx_valid`, no status pulse, FSM back in IDLE.
- Frame 0x3C with the stop bit driven low -> one-cycle `frame_error`, `rx_valid` stays 0. Line held low for 2 frames, then released -> next frame 0x55 is received correctly.
- Send 0x11 then 0x22 back-to-back with `rx_ready`=0 -> `overrun` pulses once and `rx_data` remains 0x11. Repeat with `rx_ready`=1 on the delivery cycle of 0x22 -> no overrun, `rx_data`=0x22.
- Assert `reset`, or drop `ena`, during data bit 4 -> no delivery, no pulse. The following frame 0x81 is received correctly.
- Build with `UART_RX_MAJORITY_EN` and inject a 1-cycle inverted glitch at each sample point of 0x96 -> `rx_data`=0x96.
